ps2_command_tx: RTL and testbench

PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

---
 rtl/ps2_command_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_command_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts a byte plus odd parity on device clock falling edges and checks the ACK.
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       done,
    output logic       error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);
    localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BIT_W-1:0]   bit_q, bit_d, bit_nxt;
    logic [INH_W-1:0]   inh_q, inh_d;
    logic [TO_W-1:0]    to_q, to_d, to_inc;
    logic               clk_low_q, clk_low_d;
    logic               dat_low_q, dat_low_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               clk_meta_q, clk_sync_q, clk_prev_q;
    logic               dat_meta_q, dat_sync_q;
    logic               fe, timeout;

    assign PS2_CLK   = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT   = dat_low_q ? 1'b0 : 1'bz;
    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign error     = error_q;

    // Two-flop synchronisers; reset high so no falling edge appears out of reset
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fe = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        bit_nxt   = bit_q + BIT_W'(1);
        to_inc    = (to_q == TO_W'(TIMEOUT_CYCLES)) ? to_q : to_q + TO_W'(1);
        to_d      = fe ? '0 : to_inc;
        timeout   = !fe && (to_inc == TO_W'(TIMEOUT_CYCLES));

        case (state_q)
            IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                to_d      = '0;
                if (cmd_valid) begin
                    frame_d   = {~^cmd_data, cmd_data};
                    inh_d     = '0;
                    clk_low_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                to_d = '0;
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            default: begin
                // Every device-clocked state is guarded by the edge-to-edge timeout
                if (timeout) begin
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    case (state_q)
                        RTS: begin
                            if (fe) begin
                                bit_d     = '0;
                                dat_low_d = ~frame_q[0];
                                state_d   = SHIFT;
                            end
                        end
                        SHIFT: begin
                            if (fe) begin
                                // After parity the line is released: stop bit, then ACK window
                                if (bit_q == BIT_W'(FRAME_W - 1)) begin
                                    dat_low_d = 1'b0;
                                    to_d      = '0;
                                    state_d   = ACK;
                                end else begin
                                    bit_d     = bit_nxt;
                                    dat_low_d = ~frame_q[bit_nxt];
                                end
                            end
                        end
                        ACK: begin
                            if (fe) begin
                                if (dat_sync_q) begin
                                    error_d = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    to_d    = '0;
                                    state_d = RELEASE;
                                end
                            end
                        end
                        RELEASE: begin
                            if (clk_sync_q && dat_sync_q) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                        default: begin
                            clk_low_d = 1'b0;
                            dat_low_d = 1'b0;
                            state_d   = IDLE;
                        end
                    endcase
                end
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a behavioural PS/2 device on the open-drain lines
// plus a per-cycle checker of the handshake outputs.
`timescale 1ns/1ps
module tb_ps2_command_tx;
    localparam int unsigned INHIBIT = 60;
    localparam int unsigned TIMEOUT = 500;
    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;
    localparam int M_RESET = 3;

    logic       clk;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       done;
    logic       error;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low;
    logic       dev_dat_low;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   started = 0;
    int   ended = 0;
    int   aborted = 0;
    logic chk_en = 1'b0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .done     (done),
        .error    (error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wire order of one frame: start, data LSB-first, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle output checker
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("done_error_exclusive", 32'(done & error), 32'(0));
            if (started != ended + aborted) begin
                chk("ready_low_in_transfer", 32'(cmd_ready), 32'(done | error));
                if (done | error) ended++;
            end else begin
                chk("ready_high_idle", 32'(cmd_ready), 32'(1));
                chk("no_pulse_idle", 32'(done | error), 32'(0));
                if (!dev_clk_low && !dev_dat_low)
                    chk("lines_released_idle", 32'({ps2_clk, ps2_dat}), 32'(3));
            end
            if (prev_done) chk("done_one_cycle", 32'(done), 32'(0));
            if (prev_err)  chk("error_one_cycle", 32'(error), 32'(0));
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
        prev_done = done;
        prev_err  = error;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        chk("ready_before_send", 32'(cmd_ready), 32'(1));
        cmd_data  = b;
        cmd_valid = 1'b1;
        started++;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    // Behavioural device: checks inhibit, clocks the frame in, then ACKs/NACKs/stalls/resets
    task automatic device_xfer(input int mode, input logic [7:0] b, input int h,
                               output logic [10:0] got);
        logic [10:0] exp_f;
        int n;
        int e0;
        int d0;
        exp_f = model_frame(b);
        got   = '0;
        e0    = err_cnt;
        d0    = done_cnt;
        n     = 0;
        while (ps2_clk === 1'b0 && n < int'(INHIBIT) + 50) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_cycles", 32'(n), 32'(INHIBIT));
        chk("rts_start_bit", 32'(ps2_dat), 32'(0));
        if (mode == M_NOCLK) begin
            n = 0;
            while (error !== 1'b1 && n < int'(TIMEOUT) + 50) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 32'(n), 32'(TIMEOUT));
            chk("timeout_lines_released", 32'({ps2_clk, ps2_dat}), 32'(3));
            repeat (5) @(negedge clk);
            chk("timeout_no_done", 32'(done_cnt - d0), 32'(0));
            chk("timeout_one_error", 32'(err_cnt - e0), 32'(1));
            return;
        end
        for (int i = 0; i < 11; i++) begin
            repeat (h) @(negedge clk);
            got[i] = ps2_dat;
            if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
            repeat (h) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == 10 && mode == M_NACK) begin
                // two sync stages plus the registered pulse
                n = 0;
                while (error !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("nack_error_latency", 32'(n), 32'(3));
                chk("nack_dat_released", 32'(ps2_dat), 32'(1));
            end
            repeat (2 * h) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i == 10) dev_dat_low = 1'b0;
            if (mode == M_RESET && i == 3) begin
                @(negedge clk);
                resetn = 1'b0;
                aborted++;
                @(negedge clk);
                chk("reset_lines_released", 32'({ps2_clk, ps2_dat}), 32'(3));
                chk("reset_ready", 32'(cmd_ready), 32'(1));
                chk("reset_no_pulse", 32'({done, error}), 32'(0));
                resetn = 1'b1;
                repeat (4 * h) @(negedge clk);
                chk("reset_partial_frame", 32'(got[3:0]), 32'(exp_f[3:0]));
                chk("reset_no_done", 32'(done_cnt - d0), 32'(0));
                chk("reset_no_error", 32'(err_cnt - e0), 32'(0));
                return;
            end
        end
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("frame_bits", 32'(got), 32'(exp_f));
        chk("done_count", 32'(done_cnt - d0), 32'(mode == M_ACK ? 1 : 0));
        chk("error_count", 32'(err_cnt - e0), 32'(mode == M_NACK ? 1 : 0));
    endtask

    logic [10:0] got;
    logic [10:0] pin;
    logic [7:0]  rb;
    int          rmode;

    initial begin
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("reset_done_error", 32'({done, error}), 32'(0));
        chk("reset_lines", 32'({ps2_clk, ps2_dat}), 32'(3));
        resetn = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hED);
        device_xfer(M_ACK, 8'hED, 10, got);
        pin = {2'b11, 8'hED, 1'b0};
        chk("ed_frame_literal", 32'(got), 32'(pin));

        send(8'h00);
        device_xfer(M_ACK, 8'h00, 10, got);
        chk("parity_00", 32'(got[9]), 32'(1));
        send(8'hF4);
        device_xfer(M_ACK, 8'hF4, 12, got);
        chk("parity_f4", 32'(got[9]), 32'(0));

        rb = 8'($urandom);
        send(rb);
        device_xfer(M_NACK, rb, 10, got);

        rb = 8'($urandom);
        send(rb);
        device_xfer(M_NOCLK, rb, 10, got);

        rb = 8'($urandom);
        send(rb);
        device_xfer(M_RESET, rb, 10, got);
        send(8'hFF);
        device_xfer(M_ACK, 8'hFF, 10, got);
        chk("parity_ff", 32'(got[9]), 32'(1));

        send(8'hAA);
        fork
            device_xfer(M_ACK, 8'hAA, 10, got);
            begin
                repeat (100) @(negedge clk);
                cmd_data  = 8'h55;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        join
        chk("busy_ignored_data", 32'(got[8:1]), 32'(8'hAA));
        chk("parity_aa", 32'(got[9]), 32'(1));
        repeat (100) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            rb    = 8'($urandom);
            rmode = int'($urandom_range(0, 1));
            send(rb);
            device_xfer(rmode, rb, int'($urandom_range(8, 20)), got);
        end

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
